// File: rtl/auto_contrast_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// auto_contrast_ctrl_pkg
// Purpose : Shared types and constants for the auto-contrast control loop.
//           FSM state encoding, luma field position inside the 24-bit pixel,
//           contrast level range, and helpers that derive the clamped dead-band
//           thresholds.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package auto_contrast_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_EVAL   = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  localparam int Y_MSB = 7;
  localparam int Y_LSB = 0;

  localparam logic [3:0] LEVEL_MIN = 4'd0;
  localparam logic [3:0] LEVEL_MAX = 4'd15;

  // Lower edge of the dead band, computed in 9 bits and clamped at 0.
  function automatic logic [7:0] thr_low(input logic [7:0] target, input logic [7:0] hyst);
    logic [8:0] diff;
    diff = {1'b0, target} - {1'b0, hyst};
    return diff[8] ? 8'd0 : diff[7:0];
  endfunction

  // Upper edge of the dead band, computed in 9 bits and clamped at 255.
  function automatic logic [7:0] thr_high(input logic [7:0] target, input logic [7:0] hyst);
    logic [8:0] sum;
    sum = {1'b0, target} + {1'b0, hyst};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/auto_contrast_ctrl_frame_stats.sv
// ---------------------------------------------------------------------------
// frame_stats
// Purpose : Running min/max tracker for luma over a statistics window.
//           Outputs are the statistics *including* the current pixel, so a
//           window can be closed on the same cycle a pixel arrives and that
//           pixel still belongs to the closing window.
// Ports   :
//   clk      in   1  clock
//   rst      in   1  synchronous active-high reset
//   i_de     in   1  pixel valid
//   i_y      in   8  luma of the current pixel
//   i_clear  in   1  start a new window (registers return to empty)
//   o_min    out  8  minimum luma so far, current pixel included
//   o_max    out  8  maximum luma so far, current pixel included
//   o_seen   out  1  at least one valid pixel so far, current pixel included
// ---------------------------------------------------------------------------
module frame_stats (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_de,
  input  logic [7:0] i_y,
  input  logic       i_clear,
  output logic [7:0] o_min,
  output logic [7:0] o_max,
  output logic       o_seen
);

  logic [7:0] r_min;
  logic [7:0] r_max;
  logic       r_seen;

  assign o_min  = (i_de && (i_y < r_min)) ? i_y : r_min;
  assign o_max  = (i_de && (i_y > r_max)) ? i_y : r_max;
  assign o_seen = r_seen | i_de;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      // On a clear the current pixel has already been folded into the
      // closing window through the merged outputs, so it is dropped here.
      r_min  <= 8'hFF;
      r_max  <= 8'h00;
      r_seen <= 1'b0;
    end else if (i_de) begin
      r_min  <= o_min;
      r_max  <= o_max;
      r_seen <= 1'b1;
    end
  end

endmodule

// File: rtl/auto_contrast_ctrl.sv
// ---------------------------------------------------------------------------
// auto_contrast_ctrl
// Purpose : Closed-loop controller for the contrast stage. Measures the luma
//           spread (max Y - min Y) over a window of FRAMES_STEP frames and, once
//           per window, issues at most one single-cycle inc or dec pulse to pull
//           the spread toward TARGET. The resulting level change is confirmed by
//           watching level_in; a pulse that does not move the level sets sat.
// Ports   :
//   clk         in   1   pixel clock
//   rst         in   1   synchronous active-high reset
//   en          in   1   loop enable (stats are collected regardless)
//   vsync       in   1   frame sync, rising edge marks a frame boundary
//   de          in   1   pixel valid
//   pixel_in    in   24  pixel from the contrast stage, Y in [7:0]
//   level_in    in   4   current contrast level read back
//   inc         out  1   one-cycle request to raise contrast one step
//   dec         out  1   one-cycle request to lower contrast one step
//   busy        out  1   high while evaluating or settling
//   sat         out  1   sticky: last pulse produced no level change
//   spread_out  out  8   last evaluated spread
// ---------------------------------------------------------------------------
module auto_contrast_ctrl
  import auto_contrast_ctrl_pkg::*;
#(
  parameter logic [7:0] TARGET      = 8'd200,
  parameter logic [7:0] HYST        = 8'd16,
  parameter logic [3:0] FRAMES_STEP = 4'd2,
  parameter logic [2:0] SETTLE_TO   = 3'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        vsync,
  input  logic        de,
  input  logic [23:0] pixel_in,
  input  logic [3:0]  level_in,
  output logic        inc,
  output logic        dec,
  output logic        busy,
  output logic        sat,
  output logic [7:0]  spread_out
);

  // A zero step count or settle timeout behaves as one.
  localparam logic [3:0] FRAMES_EFF = (FRAMES_STEP == 4'd0) ? 4'd1 : FRAMES_STEP;
  localparam logic [2:0] SETTLE_EFF = (SETTLE_TO == 3'd0) ? 3'd1 : SETTLE_TO;
  localparam logic [7:0] THR_LO     = thr_low(TARGET, HYST);
  localparam logic [7:0] THR_HI     = thr_high(TARGET, HYST);

  state_t     r_state, w_state_next;
  logic       r_vsync_d1, r_vsync_d2;
  logic [3:0] r_frame_cnt, w_frame_cnt_next;
  logic [7:0] r_spread, w_spread_next;
  logic       r_win_seen, w_win_seen_next;
  logic [7:0] r_spread_out, w_spread_out_next;
  logic       r_inc, w_inc_next;
  logic       r_dec, w_dec_next;
  logic       r_sat, w_sat_next;
  logic [3:0] r_lvl0, w_lvl0_next;
  logic [2:0] r_settle_cnt, w_settle_cnt_next;

  logic [7:0] w_y;
  logic [7:0] w_min;
  logic [7:0] w_max;
  logic       w_seen;
  logic       w_stats_clear;
  logic       w_vs_edge;
  logic       w_win_done;
  logic       w_unused_pix;

  assign w_y          = pixel_in[Y_MSB:Y_LSB];
  assign w_unused_pix = ^pixel_in[23:Y_MSB+1];

  frame_stats u_stats (
    .clk     (clk),
    .rst     (rst),
    .i_de    (de),
    .i_y     (w_y),
    .i_clear (w_stats_clear),
    .o_min   (w_min),
    .o_max   (w_max),
    .o_seen  (w_seen)
  );

  // Edge is taken between two registered copies of vsync, so the boundary
  // acts one cycle after vsync is first sampled high.
  assign w_vs_edge  = r_vsync_d1 & ~r_vsync_d2;
  // frame_cnt keeps counting outside ACCUM, so a window completed there is
  // still recognised at the next edge seen back in ACCUM.
  assign w_win_done = w_vs_edge && (({1'b0, r_frame_cnt} + 5'd1) >= {1'b0, FRAMES_EFF});

  always_comb begin
    w_state_next      = r_state;
    w_frame_cnt_next  = r_frame_cnt;
    w_spread_next     = r_spread;
    w_win_seen_next   = r_win_seen;
    w_spread_out_next = r_spread_out;
    w_inc_next        = 1'b0;
    w_dec_next        = 1'b0;
    w_sat_next        = r_sat;
    w_lvl0_next       = r_lvl0;
    w_settle_cnt_next = r_settle_cnt;
    w_stats_clear     = 1'b0;

    // Saturate so a long stay outside ACCUM cannot wrap the count.
    if (w_vs_edge && (r_frame_cnt != 4'hF)) begin
      w_frame_cnt_next = r_frame_cnt + 4'd1;
    end

    unique case (r_state)
      ST_ACCUM: begin
        if (w_win_done) begin
          w_spread_next    = w_seen ? (w_max - w_min) : 8'd0;
          w_win_seen_next  = w_seen;
          w_stats_clear    = 1'b1;
          w_frame_cnt_next = 4'd0;
          w_state_next     = ST_EVAL;
        end
      end

      ST_EVAL: begin
        w_spread_out_next = r_spread;
        w_state_next      = ST_ACCUM;
        if (r_win_seen && en) begin
          if (r_spread < THR_LO) begin
            if (level_in < LEVEL_MAX) begin
              w_inc_next        = 1'b1;
              w_lvl0_next       = level_in;
              w_settle_cnt_next = 3'd0;
              w_state_next      = ST_SETTLE;
            end else begin
              w_sat_next = 1'b1;
            end
          end else if (r_spread > THR_HI) begin
            if (level_in > LEVEL_MIN) begin
              w_dec_next        = 1'b1;
              w_lvl0_next       = level_in;
              w_settle_cnt_next = 3'd0;
              w_state_next      = ST_SETTLE;
            end else begin
              w_sat_next = 1'b1;
            end
          end
        end
      end

      ST_SETTLE: begin
        if (level_in != r_lvl0) begin
          w_sat_next   = 1'b0;
          w_state_next = ST_ACCUM;
        end else if (({1'b0, r_settle_cnt} + 4'd1) >= {1'b0, SETTLE_EFF}) begin
          w_sat_next   = 1'b1;
          w_state_next = ST_ACCUM;
        end else begin
          w_settle_cnt_next = r_settle_cnt + 3'd1;
        end
      end

      default: begin
        w_state_next = ST_ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_ACCUM;
      r_vsync_d1   <= 1'b0;
      r_vsync_d2   <= 1'b0;
      r_frame_cnt  <= 4'd0;
      r_spread     <= 8'd0;
      r_win_seen   <= 1'b0;
      r_spread_out <= 8'd0;
      r_inc        <= 1'b0;
      r_dec        <= 1'b0;
      r_sat        <= 1'b0;
      r_lvl0       <= 4'd0;
      r_settle_cnt <= 3'd0;
    end else begin
      r_state      <= w_state_next;
      r_vsync_d1   <= vsync;
      r_vsync_d2   <= r_vsync_d1;
      r_frame_cnt  <= w_frame_cnt_next;
      r_spread     <= w_spread_next;
      r_win_seen   <= w_win_seen_next;
      r_spread_out <= w_spread_out_next;
      r_inc        <= w_inc_next;
      r_dec        <= w_dec_next;
      r_sat        <= w_sat_next;
      r_lvl0       <= w_lvl0_next;
      r_settle_cnt <= w_settle_cnt_next;
    end
  end

  assign inc        = r_inc;
  assign dec        = r_dec;
  assign busy       = (r_state != ST_ACCUM);
  assign sat        = r_sat;
  assign spread_out = r_spread_out;

endmodule
